// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, a 2-entry {pc, instr}
// queue toward decode, and redirect handling that drops in-flight responses.
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WAIT_DROP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] fetch_addr;
    logic [WIDTH-1:0] fifo_pc    [2];
    logic [WIDTH-1:0] fifo_instr [2];
    logic             head;
    logic [1:0]       count;
    logic             issue;
    logic             push;
    logic             pop;
    logic             wr_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A response that arrives with or after a redirect belongs to the old path and is never pushed.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect_valid && count != 2'd2) begin
                    issue      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    push       = !redirect_valid;
                    state_next = IDLE;
                end else if (redirect_valid) begin
                    state_next = WAIT_DROP;
                end
            end
            WAIT_DROP: begin
                if (imem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pop    = (count != 2'd0) && out_ready;
    assign wr_idx = head ^ count[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            fetch_addr <= RESET_PC;
        end else begin
            if (redirect_valid) begin
                pc <= {redirect_pc[WIDTH-1:2], 2'b00};
            end else if (issue) begin
                pc <= pc + WIDTH'(4);
            end
            if (issue) begin
                fetch_addr <= pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= 1'b0;
            count <= 2'd0;
        end else if (redirect_valid) begin
            head  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (pop) begin
                head <= ~head;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // Entry storage needs no reset: it is only observed while count says it is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_idx]    <= fetch_addr;
            fifo_instr[wr_idx] <= imem_rdata;
        end
    end

    assign imem_req  = (state != IDLE);
    assign imem_addr = fetch_addr;
    assign out_valid = (count != 2'd0);
    assign out_pc    = out_valid ? fifo_pc[head]    : '0;
    assign out_instr = out_valid ? fifo_instr[head] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a queue-based reference model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    // Reference model: next PC, address in flight, whether a request is pending and whether its data is stale.
    entry_t      mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_fetch;
    bit          m_busy;
    bit          m_drop;

    int n_checks = 0;
    int n_fail   = 0;
    int req_age  = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_pc    = 32'h0;
        m_fetch = 32'h0;
        m_busy  = 0;
        m_drop  = 0;
    endtask

    task automatic modelStep(input bit a, input logic [31:0] d, input bit rv,
                             input logic [31:0] rp, input bit rd);
        int size0;
        size0 = mq.size();
        if (size0 != 0 && rd) void'(mq.pop_front());
        if (m_busy && a) begin
            if (!m_drop && !rv) mq.push_back('{m_fetch, d});
            m_busy = 0;
            m_drop = 0;
        end else if (m_busy && rv) begin
            m_drop = 1;
        end else if (!m_busy && !rv && size0 < 2) begin
            m_fetch = m_pc;
            m_pc    = m_pc + 32'd4;
            m_busy  = 1;
        end
        if (rv) begin
            mq.delete();
            m_pc = rp & ~32'h3;
        end
        if (mq.size() > 2) begin
            n_fail++;
            $display("[TB] FAIL model_overflow: size %0d, limit 2", mq.size());
        end
    endtask

    task automatic checkOutput();
        checkVal("imem_req", {31'b0, imem_req}, {31'b0, m_busy});
        checkVal("imem_addr", imem_addr, m_fetch);
        checkVal("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
        checkVal("out_pc", out_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
        checkVal("out_instr", out_instr, (mq.size() != 0) ? mq[0].instr : 32'h0);
    endtask

    // Inputs change on the falling edge; the model advances on the rising edge; outputs are compared on the next falling edge.
    task automatic applyStimulus(input bit r, input bit a, input logic [31:0] d, input bit rv,
                                 input logic [31:0] rp, input bit rd);
        rst            = r;
        imem_ack       = a;
        imem_rdata     = d;
        redirect_valid = rv;
        redirect_pc    = rp;
        out_ready      = rd;
        if (r) modelReset();
        @(posedge clk);
        if (!r) modelStep(a, d, rv, rp, rd);
        @(negedge clk);
        checkOutput();
    endtask

    // Memory responder: acks a pending request once it has been visible for 'delay' cycles.
    task automatic autoStep(input bit rd, input int delay);
        bit a;
        a = imem_req && (req_age >= delay);
        applyStimulus(0, a, mem_word(imem_addr), 0, 32'h0, rd);
        if (a || !imem_req) req_age = 0;
        else req_age++;
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
        applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
        req_age = 0;
    endtask

    // Fill the queue with out_ready low so the unit parks in IDLE, then redirect from IDLE.
    task automatic fillAndRedirect(input logic [31:0] target);
        for (int i = 0; i < 10; i++) autoStep(0, 0);
        checkVal("fill_req_idle", {31'b0, imem_req}, 32'h0);
        applyStimulus(0, 0, 32'h0, 1, target, 0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
        checkVal("redirect_req", {31'b0, imem_req}, 32'h1);
        checkVal("redirect_addr", imem_addr, target & ~32'h3);
    endtask

    initial begin
        logic [31:0] got_pc[4];
        logic [31:0] got_in[4];
        int          n_got;
        bit          found;

        rst = 1'b1; imem_ack = 0; imem_rdata = 0; redirect_valid = 0; redirect_pc = 0; out_ready = 0;
        modelReset();
        @(negedge clk);

        // Reset state and in-order streaming with a 1-cycle ack.
        doReset();
        checkVal("reset_req", {31'b0, imem_req}, 32'h0);
        checkVal("reset_valid", {31'b0, out_valid}, 32'h0);
        checkVal("reset_out_pc", out_pc, 32'h0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
        checkVal("first_req", {31'b0, imem_req}, 32'h1);
        checkVal("first_addr", imem_addr, 32'h0);
        req_age = 0;
        n_got = 0;
        for (int i = 0; i < 60 && n_got < 4; i++) begin
            if (out_valid) begin
                got_pc[n_got] = out_pc;
                got_in[n_got] = out_instr;
                n_got++;
            end
            if (n_got < 4) autoStep(1, 1);
        end
        checkVal("stream_count", n_got, 4);
        checkVal("stream_pc0", got_pc[0], 32'h0);
        checkVal("stream_pc1", got_pc[1], 32'h4);
        checkVal("stream_pc2", got_pc[2], 32'h8);
        checkVal("stream_pc3", got_pc[3], 32'hC);
        checkVal("stream_in0", got_in[0], 32'hC0DE_0000);
        checkVal("stream_in3", got_in[3], 32'hC0D2_000C);

        // Backpressure: two entries, no further request, one pop releases fetch at 8.
        doReset();
        for (int i = 0; i < 12; i++) autoStep(0, 0);
        checkVal("full_req", {31'b0, imem_req}, 32'h0);
        checkVal("full_head_pc", out_pc, 32'h0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
        checkVal("pop_head_pc", out_pc, 32'h4);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
        checkVal("refetch_req", {31'b0, imem_req}, 32'h1);
        checkVal("refetch_addr", imem_addr, 32'h8);

        // Redirect while waiting at 4 with a late ack: the word is dropped.
        doReset();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_req && imem_addr == 32'h4) found = 1;
            else autoStep(1, 0);
        end
        checkVal("reach_addr4", {31'b0, found}, 32'h1);
        applyStimulus(0, 0, 32'h0, 1, 32'h100, 1);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
        checkVal("drop_req_held", {31'b0, imem_req}, 32'h1);
        applyStimulus(0, 1, 32'hDEAD_BEEF, 0, 32'h0, 1);
        checkVal("drop_no_push", {31'b0, out_valid}, 32'h0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
        checkVal("drop_next_addr", imem_addr, 32'h100);

        // Redirect coinciding with ack in WAIT.
        applyStimulus(0, 1, 32'h1234_5678, 1, 32'h340, 1);
        checkVal("coinc_req", {31'b0, imem_req}, 32'h0);
        checkVal("coinc_valid", {31'b0, out_valid}, 32'h0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
        checkVal("coinc_addr", imem_addr, 32'h340);

        // PC wrap and redirect alignment.
        fillAndRedirect(32'hFFFF_FFFC);
        applyStimulus(0, 1, 32'h0BAD_F00D, 0, 32'h0, 0);
        checkVal("wrap_head_pc", out_pc, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
        checkVal("wrap_addr", imem_addr, 32'h0);
        fillAndRedirect(32'h203);

        // Reset in the middle of a wait, ack while reset is held.
        applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
        applyStimulus(1, 1, 32'h5555_AAAA, 0, 32'h0, 0);
        checkVal("rst_valid", {31'b0, out_valid}, 32'h0);
        checkVal("rst_instr", out_instr, 32'h0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
        checkVal("rst_first_req", {31'b0, imem_req}, 32'h1);
        checkVal("rst_first_addr", imem_addr, 32'h0);

        // Random traffic: acks also arrive while idle, occasional redirects and resets.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), $urandom(),
                          ($urandom_range(0, 15) == 0), $urandom(), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
